// File: rtl/count_arbiter.sv
// count_arbiter: two debounced buttons arbitrate step strobes to an up/down counter.
// Optional auto-repeat while the owner holds: define AUTO_REPEAT_EN.
module count_arbiter #(
  parameter int DEB_CYCLES = 3,
  parameter int REPEAT_DLY = 4,
  parameter int REPEAT_PER = 2
) (
  input  logic       clk_out,
  input  logic       RESET,
  input  logic       btn0,
  input  logic       btn1,
  output logic       cnt_en,
  output logic       cnt_dir,
  output logic [1:0] grant,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    OWN_UP   = 2'b01,
    OWN_DN   = 2'b10,
    CONFLICT = 2'b11
  } state_t;

  localparam int DEB_E = (DEB_CYCLES < 1) ? 1 : DEB_CYCLES;
  localparam int CW = $clog2(DEB_E + 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_E - 1);

  logic [1:0]    raw;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    deb;
  logic [1:0]    deb_q;
  logic [1:0]    rise;
  logic [CW-1:0] dcnt [2];

  state_t     cur;
  state_t     nxt;
  logic       own;
  logic       en_n;
  logic       dir_n;
  logic [1:0] grant_n;
  logic       last;
  logic       last_n;

  assign raw   = {btn1, btn0};
  assign rise  = deb & ~deb_q;
  assign own   = (cur == OWN_DN);
  assign state = cur;

`ifdef AUTO_REPEAT_EN
  localparam logic [7:0] DLY_E =
    (REPEAT_DLY < 1)   ? 8'd1   :
    (REPEAT_DLY > 255) ? 8'd255 : 8'(REPEAT_DLY);
  localparam logic [7:0] PER_E =
    (REPEAT_PER < 1)   ? 8'd1   :
    (REPEAT_PER > 255) ? 8'd255 : 8'(REPEAT_PER);

  logic [7:0] tmr;
  logic [7:0] tmr_n;

  // Repeat timer: counts down to the next auto-repeat pulse.
  always_ff @(posedge clk_out) begin
    if (RESET) tmr <= '0;
    else       tmr <= tmr_n;
  end
`endif

  // Two-flop synchronizer; free-running so a button held through
  // RESET is already visible and only the debouncer sets the restart delay.
  always_ff @(posedge clk_out) begin
    sync1 <= raw;
    sync2 <= sync1;
  end

  // Debouncer: flip only after DEB_E consecutive samples at the new level.
  always_ff @(posedge clk_out) begin
    if (RESET) begin
      deb     <= '0;
      deb_q   <= '0;
      dcnt[0] <= '0;
      dcnt[1] <= '0;
    end else begin
      deb_q <= deb;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] == DEB_LAST) begin
          deb[i]  <= sync2[i];
          dcnt[i] <= '0;
        end else begin
          dcnt[i] <= dcnt[i] + CW'(1);
        end
      end
    end
  end

  // Arbiter next state and next registered outputs.
  always_comb begin
    nxt     = cur;
    en_n    = 1'b0;
    dir_n   = cnt_dir;
    grant_n = grant;
    last_n  = last;
`ifdef AUTO_REPEAT_EN
    tmr_n   = tmr;
`endif
    unique case (cur)
      IDLE: begin
        if (rise[0] && rise[1]) begin
          en_n    = 1'b1;
          dir_n   = last;
          last_n  = ~last;
          grant_n = 2'b00;
          nxt     = CONFLICT;
        end else if (rise[0]) begin
          en_n    = 1'b1;
          dir_n   = 1'b1;
          last_n  = 1'b0;
          grant_n = 2'b01;
          nxt     = OWN_UP;
`ifdef AUTO_REPEAT_EN
          tmr_n   = DLY_E;
`endif
        end else if (rise[1]) begin
          en_n    = 1'b1;
          dir_n   = 1'b0;
          last_n  = 1'b1;
          grant_n = 2'b10;
          nxt     = OWN_DN;
`ifdef AUTO_REPEAT_EN
          tmr_n   = DLY_E;
`endif
        end
      end
      OWN_UP, OWN_DN: begin
        if (!deb[own]) begin
          grant_n = 2'b00;
          nxt     = IDLE;
        end else if (rise[~own]) begin
          grant_n = 2'b00;
          nxt     = CONFLICT;
        end
`ifdef AUTO_REPEAT_EN
        else if (tmr == 8'd1) begin
          en_n  = 1'b1;
          tmr_n = PER_E;
        end else begin
          tmr_n = tmr - 8'd1;
        end
`endif
      end
      CONFLICT: begin
        if (deb == 2'b00) nxt = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_out) begin
    if (RESET) begin
      cur     <= IDLE;
      cnt_en  <= 1'b0;
      cnt_dir <= 1'b0;
      grant   <= 2'b00;
      last    <= 1'b1;
    end else begin
      cur     <= nxt;
      cnt_en  <= en_n;
      cnt_dir <= dir_n;
      grant   <= grant_n;
      last    <= last_n;
    end
  end

endmodule
